spi_reg_ctrl: RTL

- SPI-slave register controller for the ice40up5k doppler board: the samd51 configures the user IO bank and LED matrix through this block, and reads back pin state.
- Decodes framed SPI transactions into a small register file that drives LED matrix data, pin output values and per-pin output enables, and serves read-back of pin inputs.
- Sits between the raw cfg_cs/cfg_sck/cfg_si/cfg_so pins and the SB_IO/LED16 datapath, entirely in the 48 MHz internal oscillator domain.

---
 rtl/spi_reg_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// ============================================================================
//  Module   : spi_reg_ctrl
//  Purpose  : SPI-slave (mode 0) register controller driving LED matrix data,
//             user IO output values/enables and serving pin read-back.
//             Optional macro SPI_REG_AUTOINC_EN enables auto-increment bursts.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_ctrl #(
    parameter logic [15:0] ID_VALUE = 16'hD0B1,
    parameter int          ERR_W    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [23:0] pin_in,
    output logic [15:0] led_data,
    output logic [23:0] pin_out,
    output logic [23:0] pin_oe,
    output logic        busy
);

    localparam logic [2:0] S_WAIT_CS = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    logic [2:0]       r_cs_s;
    logic [2:0]       r_sck_s;
    logic [2:0]       r_mosi_s;
    logic [2:0]       r_state;
    logic [4:0]       r_bit_cnt;
    logic [6:0]       r_cmd_sh;
    logic [14:0]      r_data_sh;
    logic             r_wr;
    logic [6:0]       r_addr;
    logic [15:0]      r_miso_sh;
    logic             r_word_done;
    logic [15:0]      r_led;
    logic [23:0]      r_pout;
    logic [23:0]      r_poe;
    logic [ERR_W-1:0] r_err;

    logic             w_cs_rise;
    logic             w_cs_fall;
    logic             w_sck_rise;
    logic             w_sck_fall;
    logic             w_mosi;
    logic [6:0]       w_cmd_addr;
    logic [15:0]      w_wdata;
    logic             w_commit;
    logic             w_err_inc;

    assign w_cs_rise  = ~r_cs_s[2] &  r_cs_s[1];
    assign w_cs_fall  =  r_cs_s[2] & ~r_cs_s[1];
    assign w_sck_rise = ~r_sck_s[2] &  r_sck_s[1];
    assign w_sck_fall =  r_sck_s[2] & ~r_sck_s[1];
    assign w_mosi     = r_mosi_s[1];
    assign w_cmd_addr = {r_cmd_sh[5:0], w_mosi};
    assign w_wdata    = {r_data_sh, w_mosi};

    assign w_commit = (r_state == S_DATA) && !w_cs_rise && w_sck_rise &&
                      (r_bit_cnt == 5'd23) && r_wr;

    // A word boundary inside DATA only exists once a full word has completed.
    assign w_err_inc = w_cs_rise &&
                       ((r_state == S_CMD) ||
                        ((r_state == S_DATA) && !(r_word_done && r_bit_cnt == 5'd8)) ||
                        ((r_state == S_OVER) && (r_bit_cnt > 5'd24)));

    function automatic logic [15:0] f_read(input logic [6:0] a);
        logic [15:0] v;
        v = 16'h0000;
        case (a)
            7'h00: v = r_led;
            7'h01: v = r_pout[15:0];
            7'h02: v = {8'h00, r_pout[23:16]};
            7'h03: v = r_poe[15:0];
            7'h04: v = {8'h00, r_poe[23:16]};
            7'h05: v = pin_in[15:0];
            7'h06: v = {8'h00, pin_in[23:16]};
            7'h07: v = ID_VALUE;
            7'h08: v = 16'(r_err);
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cs_s      <= 3'b111;
            r_sck_s     <= 3'b000;
            r_mosi_s    <= 3'b000;
            r_state     <= S_WAIT_CS;
            r_bit_cnt   <= 5'd0;
            r_cmd_sh    <= 7'd0;
            r_data_sh   <= 15'd0;
            r_wr        <= 1'b0;
            r_addr      <= 7'd0;
            r_miso_sh   <= 16'hFFFF;
            r_word_done <= 1'b0;
        end else begin
            r_cs_s   <= {r_cs_s[1:0], spi_cs};
            r_sck_s  <= {r_sck_s[1:0], spi_sck};
            r_mosi_s <= {r_mosi_s[1:0], spi_mosi};

            if (r_state == S_WAIT_CS) begin
                // Let the synchronisers flush their reset value before trusting cs.
                if (r_bit_cnt < 5'd3) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end else if (r_cs_s[1]) begin
                    r_state   <= S_IDLE;
                    r_bit_cnt <= 5'd0;
                end
            end else if (r_state == S_IDLE) begin
                if (w_cs_fall) begin
                    r_state     <= S_CMD;
                    r_bit_cnt   <= 5'd0;
                    r_word_done <= 1'b0;
                end
            end else if (w_cs_rise) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 5'd0;
            end else if (r_state == S_CMD) begin
                if (w_sck_rise) begin
                    r_cmd_sh  <= w_cmd_addr;
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        r_wr      <= r_cmd_sh[6];
                        r_addr    <= w_cmd_addr;
                        r_miso_sh <= f_read(w_cmd_addr);
                        r_state   <= S_DATA;
                    end
                end
            end else if (r_state == S_DATA) begin
                if (w_sck_rise) begin
                    r_data_sh <= w_wdata[14:0];
                    if (r_bit_cnt == 5'd23) begin
                        r_word_done <= 1'b1;
`ifdef SPI_REG_AUTOINC_EN
                        r_addr      <= r_addr + 7'd1;
                        r_miso_sh   <= f_read(r_addr + 7'd1);
                        r_bit_cnt   <= 5'd8;
`else
                        r_state     <= S_OVER;
                        r_bit_cnt   <= 5'd24;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end else if (w_sck_fall && r_bit_cnt != 5'd8) begin
                    // The fall right after a word load keeps the MSB for the next rise.
                    r_miso_sh <= {r_miso_sh[14:0], 1'b1};
                end
            end else begin
                if (w_sck_rise && r_bit_cnt == 5'd24) begin
                    r_bit_cnt <= 5'd25;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_led  <= 16'd0;
            r_pout <= 24'd0;
            r_poe  <= 24'd0;
            r_err  <= '0;
        end else begin
            if (w_commit) begin
                case (r_addr)
                    7'h00: r_led          <= w_wdata;
                    7'h01: r_pout[15:0]   <= w_wdata;
                    7'h02: r_pout[23:16]  <= w_wdata[7:0];
                    7'h03: r_poe[15:0]    <= w_wdata;
                    7'h04: r_poe[23:16]   <= w_wdata[7:0];
                    default: ;
                endcase
            end
            if (w_commit && r_addr == 7'h08) begin
                r_err <= '0;
            end else if (w_err_inc && r_err != {ERR_W{1'b1}}) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

    assign spi_miso = (r_state == S_DATA) ? r_miso_sh[15] : 1'b1;
    assign busy     = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_OVER);
    assign led_data = r_led;
    assign pin_out  = r_pout;
    assign pin_oe   = r_poe;

endmodule

`default_nettype wire
